sram_req_ctrl: RTL and testbench

Parametrised single-port SRAM bank with a request/response front end. It generalises the fixed 128x8 macro model to any width and depth, and adds the following:
- valid/ready request handshake
- per-bit write mask
- configurable read-latency pipeline
- hardware clear FSM that zero-fills the array after reset or on demand
It sits between bus-side logic and the storage array, and drives the array with the macro-family active-low CEN/GWEN/WEN signalling.

---
 rtl/sram_req_ctrl_pkg.sv | 23 ++
 rtl/sram_req_ctrl_if.sv | 29 ++
 rtl/sram_req_ctrl_array.sv | 38 +++
 rtl/sram_req_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sram_req_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and constants for the request-driven SRAM bank controller.
package sram_ctrl_pkg;

  // Controller operating modes: zero-filling the array, or serving requests.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Legal range of the read-latency pipeline depth.
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  // Legal range of the data word width.
  localparam int DATA_W_MIN = 1;
  localparam int DATA_W_MAX = 64;

  // Number of words addressable with an address of the given width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Bus-side request/response bundle of the SRAM bank controller.
// master = bus-side logic issuing requests, slave = the controller.
interface sram_req_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_wmask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clr_req;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, clr_req,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, clr_req,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/sram_req_ctrl_array.sv
// Behavioural single-port storage with the macro-family active-low pin set
// (CEN chip enable, GWEN global write enable, WEN per-bit write enable).
// Kept pin-compatible so a hard macro wrapper can replace it directly.
module sram_array
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              CLK,
  input  logic              CEN,
  input  logic              GWEN,
  input  logic [DATA_W-1:0] WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Access port: bit-masked write, or registered read; Q holds on writes and idle cycles.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (!WEN[i]) begin
            mem[A][i] <= D[i];
          end
        end
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Request/response front end for a single-port SRAM bank: valid/ready
// acceptance, per-bit masked writes, a configurable read-latency pipeline
// and a clear FSM that zero-fills the array after reset or on request.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 7,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           CLK,
  input  logic           RST,
  sram_req_ctrl_if.slave bus
);

  // Reject unsupported configurations at elaboration.
  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
    $error("sram_req_ctrl: READ_LAT out of range");
  end
  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("sram_req_ctrl: DATA_W out of range");
  end

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  logic              busy_int;
  logic              ready_int;
  logic              clear_wr;
  logic              accept;
  logic              rd_accept;

  logic              arr_cen;
  logic              arr_gwen;
  logic [DATA_W-1:0] arr_wen;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_din;
  logic [DATA_W-1:0] arr_q;

  logic [READ_LAT-1:0] vld_reg;
  logic [DATA_W-1:0]   pipe_data;
  logic [DATA_W-1:0]   hold_reg;
  logic                rsp_valid_int;

  // FSM state and clear address counter; reset restarts any clear from address 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and mode-dependent handshake outputs; clr_req outranks a request.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy_int   = 1'b0;
    ready_int  = 1'b0;
    clear_wr   = 1'b0;
    case (state_reg)
      CLEAR: begin
        busy_int = 1'b1;
        clear_wr = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {ADDR_W{1'b1}}) begin
          state_next = RUN;
        end
      end
      RUN: begin
        ready_int = !bus.clr_req;
        if (bus.clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
    // Nothing touches the array or the bus while reset is held.
    if (RST) begin
      ready_int = 1'b0;
      clear_wr  = 1'b0;
    end
  end

  // Array drive: clear writes take the port, otherwise the accepted request does.
  always_comb begin
    accept    = bus.req_valid && ready_int;
    rd_accept = accept && !bus.req_we;
    arr_cen   = !(accept || clear_wr);
    arr_gwen  = clear_wr ? 1'b0 : ~bus.req_we;
    arr_wen   = clear_wr ? '0 : ~bus.req_wmask;
    arr_addr  = clear_wr ? cnt_reg : bus.req_addr;
    arr_din   = clear_wr ? '0 : bus.req_wdata;
  end

  sram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .CLK  (CLK),
    .CEN  (arr_cen),
    .GWEN (arr_gwen),
    .WEN  (arr_wen),
    .A    (arr_addr),
    .D    (arr_din),
    .Q    (arr_q)
  );

  // Read-valid tokens travel alongside the data; reset drops any in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= rd_accept;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_reg[k] <= vld_reg[k-1];
      end
    end
  end

  // Array Q already counts as the first latency cycle, so only READ_LAT-1 data stages follow it.
  if (READ_LAT == 1) begin : g_lat1
    assign pipe_data = arr_q;
  end else begin : g_pipe
    logic [DATA_W-1:0] stage_reg [READ_LAT-1];

    // Data shift stages; no reset needed since validity is tracked by vld_reg.
    always_ff @(posedge CLK) begin
      stage_reg[0] <= arr_q;
      for (int k = 1; k < READ_LAT - 1; k++) begin
        stage_reg[k] <= stage_reg[k-1];
      end
    end

    assign pipe_data = stage_reg[READ_LAT-2];
  end

  assign rsp_valid_int = vld_reg[READ_LAT-1];

  // Remember the last delivered word so rsp_rdata is stable between responses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_reg <= '0;
    end else if (rsp_valid_int) begin
      hold_reg <= pipe_data;
    end
  end

  assign bus.req_ready = ready_int;
  assign bus.busy      = busy_int;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_rdata = rsp_valid_int ? pipe_data : hold_reg;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl: four configurations sharing one clock,
// each exercised by hand-computed vectors in a single linear sequence.
module tb_sram_req_ctrl;

  logic clk;
  logic rst;
  logic rst_c;

  int checks = 0;
  int errors = 0;

  // a: 8x128 lat 1, b: 8x128 lat 3, c: 8x128 lat 2, w: 32x16 lat 1
  sram_req_ctrl_if #(.DATA_W(8),  .ADDR_W(7)) if_a ();
  sram_req_ctrl_if #(.DATA_W(8),  .ADDR_W(7)) if_b ();
  sram_req_ctrl_if #(.DATA_W(8),  .ADDR_W(7)) if_c ();
  sram_req_ctrl_if #(.DATA_W(32), .ADDR_W(4)) if_w ();

  sram_req_ctrl #(.DATA_W(8), .ADDR_W(7), .READ_LAT(1), .CLEAR_ON_RESET(1))
    dut_a (.CLK(clk), .RST(rst), .bus(if_a));
  sram_req_ctrl #(.DATA_W(8), .ADDR_W(7), .READ_LAT(3), .CLEAR_ON_RESET(1))
    dut_b (.CLK(clk), .RST(rst), .bus(if_b));
  sram_req_ctrl #(.DATA_W(8), .ADDR_W(7), .READ_LAT(2), .CLEAR_ON_RESET(1))
    dut_c (.CLK(clk), .RST(rst_c), .bus(if_c));
  sram_req_ctrl #(.DATA_W(32), .ADDR_W(4), .READ_LAT(1), .CLEAR_ON_RESET(1))
    dut_w (.CLK(clk), .RST(rst), .bus(if_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on DUT a; returns 1 ns after the accepting edge.
  task automatic a_req(input logic we, input logic [6:0] addr,
                       input logic [7:0] wd, input logic [7:0] wm);
    @(negedge clk);
    if_a.req_valid = 1'b1;
    if_a.req_we    = we;
    if_a.req_addr  = addr;
    if_a.req_wdata = wd;
    if_a.req_wmask = wm;
    @(posedge clk); #1;
    if_a.req_valid = 1'b0;
    $display("a req we=%0d addr=%02h wdata=%02h wmask=%02h -> rsp_valid=%0d rdata=%02h",
             we, addr, wd, wm, if_a.rsp_valid, if_a.rsp_rdata);
  endtask

  // One request on DUT w; returns 1 ns after the accepting edge.
  task automatic w_req(input logic we, input logic [3:0] addr,
                       input logic [31:0] wd, input logic [31:0] wm);
    @(negedge clk);
    if_w.req_valid = 1'b1;
    if_w.req_we    = we;
    if_w.req_addr  = addr;
    if_w.req_wdata = wd;
    if_w.req_wmask = wm;
    @(posedge clk); #1;
    if_w.req_valid = 1'b0;
    $display("w req we=%0d addr=%01h wdata=%08h wmask=%08h -> rsp_valid=%0d rdata=%08h",
             we, addr, wd, wm, if_w.rsp_valid, if_w.rsp_rdata);
  endtask

  logic [7:0] lat_v;
  logic [7:0] lat_d [8];
  int na, nb, nc, nw, nrdy, nv, n;

  initial begin
    rst = 1'b1;
    rst_c = 1'b1;
    if_a.req_valid = 0; if_a.req_we = 0; if_a.req_addr = '0; if_a.req_wdata = '0; if_a.req_wmask = '0; if_a.clr_req = 0;
    if_b.req_valid = 0; if_b.req_we = 0; if_b.req_addr = '0; if_b.req_wdata = '0; if_b.req_wmask = '0; if_b.clr_req = 0;
    if_c.req_valid = 0; if_c.req_we = 0; if_c.req_addr = '0; if_c.req_wdata = '0; if_c.req_wmask = '0; if_c.clr_req = 0;
    if_w.req_valid = 0; if_w.req_we = 0; if_w.req_addr = '0; if_w.req_wdata = '0; if_w.req_wmask = '0; if_w.clr_req = 0;

    // Reset for two edges: no response, not ready.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(if_a.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(if_a.rsp_rdata), 64'h0);
    chk("rst_req_ready", 64'(if_a.req_ready), 64'd0);
    chk("rst_rsp_valid_b", 64'(if_b.rsp_valid), 64'd0);

    // Release reset and measure the automatic clear on every instance.
    @(negedge clk);
    rst = 1'b0;
    rst_c = 1'b0;
    na = 0; nb = 0; nc = 0; nw = 0; nrdy = 0;
    repeat (200) begin
      #1;
      if (if_a.busy) na++;
      if (if_b.busy) nb++;
      if (if_c.busy) nc++;
      if (if_w.busy) nw++;
      if (if_a.busy && if_a.req_ready) nrdy++;
      @(negedge clk);
    end
    $display("reset clear busy cycles a=%0d b=%0d c=%0d w=%0d ready_while_busy=%0d", na, nb, nc, nw, nrdy);
    chk("clr_len_a", 64'(na), 64'd128);
    chk("clr_len_b", 64'(nb), 64'd128);
    chk("clr_len_c", 64'(nc), 64'd128);
    chk("clr_len_w", 64'(nw), 64'd16);
    chk("ready_while_busy", 64'(nrdy), 64'd0);
    chk("ready_after_clr", 64'(if_a.req_ready), 64'd1);

    // Cleared contents at the first, middle and last address.
    a_req(1'b0, 7'h00, 8'h00, 8'h00);
    chk("rd00_valid", 64'(if_a.rsp_valid), 64'd1);
    chk("rd00_data", 64'(if_a.rsp_rdata), 64'h00);
    a_req(1'b0, 7'h3F, 8'h00, 8'h00);
    chk("rd3f_data", 64'(if_a.rsp_rdata), 64'h00);
    a_req(1'b0, 7'h7F, 8'h00, 8'h00);
    chk("rd7f_data", 64'(if_a.rsp_rdata), 64'h00);

    // Masked write then read-after-write on consecutive cycles.
    a_req(1'b1, 7'h10, 8'hFF, 8'hFF);
    chk("wr_no_rsp", 64'(if_a.rsp_valid), 64'd0);
    a_req(1'b1, 7'h10, 8'h00, 8'h0F);
    a_req(1'b0, 7'h10, 8'h00, 8'h00);
    chk("mask_valid", 64'(if_a.rsp_valid), 64'd1);
    chk("mask_data", 64'(if_a.rsp_rdata), 64'hF0);
    @(posedge clk); #1;
    chk("hold_valid", 64'(if_a.rsp_valid), 64'd0);
    chk("hold_data", 64'(if_a.rsp_rdata), 64'hF0);

    // READ_LAT=3: prefill 1..4, four back-to-back reads, responses on cycles 2..5.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if_b.req_valid = 1'b1;
      if_b.req_we    = 1'b1;
      if_b.req_addr  = 7'(i);
      if_b.req_wdata = 8'(i);
      if_b.req_wmask = 8'hFF;
      @(posedge clk); #1;
      if_b.req_valid = 1'b0;
      $display("b req we=1 addr=%02h wdata=%02h wmask=ff", i, i);
    end
    lat_v = 8'b0011_1100;
    lat_d = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 4) begin
        if_b.req_valid = 1'b1;
        if_b.req_we    = 1'b0;
        if_b.req_addr  = 7'(i + 1);
      end else begin
        if_b.req_valid = 1'b0;
      end
      @(posedge clk); #1;
      $display("b cycle %0d rsp_valid=%0d rdata=%02h", i, if_b.rsp_valid, if_b.rsp_rdata);
      chk($sformatf("lat3_valid_%0d", i), 64'(if_b.rsp_valid), 64'(lat_v[i]));
      if (lat_v[i]) chk($sformatf("lat3_data_%0d", i), 64'(if_b.rsp_rdata), 64'(lat_d[i]));
    end

    // clr_req beats a simultaneous read; a second clr_req mid-clear is ignored.
    a_req(1'b1, 7'h05, 8'h5A, 8'hFF);
    @(negedge clk);
    if_a.clr_req   = 1'b1;
    if_a.req_valid = 1'b1;
    if_a.req_we    = 1'b0;
    if_a.req_addr  = 7'h05;
    #1;
    chk("prio_ready", 64'(if_a.req_ready), 64'd0);
    @(posedge clk); #1;
    if_a.clr_req   = 1'b0;
    if_a.req_valid = 1'b0;
    chk("prio_no_rsp", 64'(if_a.rsp_valid), 64'd0);
    chk("prio_busy", 64'(if_a.busy), 64'd1);
    n = 0;
    while (if_a.busy === 1'b1 && n < 300) begin
      n++;
      if_a.clr_req = (n == 50);
      @(posedge clk); #1;
    end
    if_a.clr_req = 1'b0;
    $display("clear on request busy cycles=%0d", n);
    chk("prio_clr_len", 64'(n), 64'd128);
    a_req(1'b0, 7'h05, 8'h00, 8'h00);
    chk("prio_rd_valid", 64'(if_a.rsp_valid), 64'd1);
    chk("prio_rd_data", 64'(if_a.rsp_rdata), 64'h00);

    // READ_LAT=2: reset the edge after a read is accepted; the response is lost.
    @(negedge clk);
    if_c.req_valid = 1'b1; if_c.req_we = 1'b1; if_c.req_addr = 7'h09;
    if_c.req_wdata = 8'h77; if_c.req_wmask = 8'hFF;
    @(negedge clk);
    if_c.req_we = 1'b0;
    @(posedge clk); #1;
    if_c.req_valid = 1'b0;
    @(negedge clk);
    rst_c = 1'b1;
    @(posedge clk); #1;
    $display("c reset mid-flight rsp_valid=%0d rdata=%02h", if_c.rsp_valid, if_c.rsp_rdata);
    chk("midrst_no_rsp", 64'(if_c.rsp_valid), 64'd0);
    chk("midrst_rdata", 64'(if_c.rsp_rdata), 64'h00);
    @(negedge clk);
    rst_c = 1'b0;
    nc = 0; nv = 0;
    repeat (200) begin
      #1;
      if (if_c.busy) nc++;
      if (if_c.rsp_valid) nv++;
      @(negedge clk);
    end
    $display("c restarted clear busy cycles=%0d stray responses=%0d", nc, nv);
    chk("midrst_clr_len", 64'(nc), 64'd128);
    chk("midrst_stray", 64'(nv), 64'd0);
    @(negedge clk);
    if_c.req_valid = 1'b1; if_c.req_we = 1'b0; if_c.req_addr = 7'h09;
    @(posedge clk); #1;
    if_c.req_valid = 1'b0;
    @(posedge clk); #1;
    $display("c read addr=09 -> rsp_valid=%0d rdata=%02h", if_c.rsp_valid, if_c.rsp_rdata);
    chk("lat2_valid", 64'(if_c.rsp_valid), 64'd1);
    chk("lat2_data", 64'(if_c.rsp_rdata), 64'h00);

    // Wide configuration: masked 32-bit writes at the top address.
    w_req(1'b0, 4'hF, 32'h0, 32'h0);
    chk("w_clr_data", 64'(if_w.rsp_rdata), 64'h0);
    w_req(1'b1, 4'hF, 32'hDEADBEEF, 32'hFFFF0000);
    w_req(1'b0, 4'hF, 32'h0, 32'h0);
    chk("w_hi_valid", 64'(if_w.rsp_valid), 64'd1);
    chk("w_hi_data", 64'(if_w.rsp_rdata), 64'hDEAD0000);
    w_req(1'b1, 4'hF, 32'h12345678, 32'h0000FFFF);
    w_req(1'b0, 4'hF, 32'h0, 32'h0);
    chk("w_lo_data", 64'(if_w.rsp_rdata), 64'hDEAD5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
